// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - job, operand, MAC-side and result signal bundle for mac_seq_ctrl
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_INT_WIDTH
`define MAC_INT_WIDTH 32
`endif
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 4
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'd0
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'd1
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'd2
`endif

interface mac_seq_ctrl_if #(
    parameter int LEN_W = 8
);
    // job request from the host/fabric
    logic                                     job_valid;
    logic                                     job_ready;
    logic [1:0]                               job_mode;
    logic                                     job_acc;
    logic [`MAC_ACC_WIDTH-1:0]                job_init;
    logic [LEN_W-1:0]                         job_len;
    // operand beat stream
    logic                                     op_valid;
    logic                                     op_ready;
    logic [4*`MAC_MIN_WIDTH-1:0]              op_a;
    logic [`MAC_MIN_WIDTH-1:0]                op_b;
    // MAC datapath side
    logic                                     mac_en;
    logic [`MAC_ACC_WIDTH+`MAC_CONF_WIDTH-1:0] mac_cfg;
    logic [`MAC_MIN_WIDTH-1:0]                mac_a0;
    logic [`MAC_MIN_WIDTH-1:0]                mac_a1;
    logic [`MAC_MIN_WIDTH-1:0]                mac_a2;
    logic [`MAC_MIN_WIDTH-1:0]                mac_a3;
    logic [`MAC_MIN_WIDTH-1:0]                mac_b2;
    logic [`MAC_INT_WIDTH-1:0]                mac_c;
    // result return
    logic                                     res_valid;
    logic                                     res_ready;
    logic [`MAC_INT_WIDTH-1:0]                res_data;

    // sequencer side
    modport master (
        input  job_valid, job_mode, job_acc, job_init, job_len,
        output job_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output mac_en, mac_cfg, mac_a0, mac_a1, mac_a2, mac_a3, mac_b2,
        input  mac_c,
        output res_valid, res_data,
        input  res_ready
    );

    // host, operand source, MAC and result consumer side
    modport slave (
        output job_valid, job_mode, job_acc, job_init, job_len,
        input  job_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  mac_en, mac_cfg, mac_a0, mac_a1, mac_a2, mac_a3, mac_b2,
        output mac_c,
        input  res_valid, res_data,
        output res_ready
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - job sequencer for one MAC block; MAC_SEQ_STALL_CNT_EN adds stall_cnt
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_INT_WIDTH
`define MAC_INT_WIDTH 32
`endif
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 4
`endif

module mac_seq_ctrl #(
    parameter int LEN_W       = 8,
    parameter int MAC_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_seq_ctrl_if.master       bus,
    output logic                 busy
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int MIN_W  = `MAC_MIN_WIDTH;
    localparam int INT_W  = `MAC_INT_WIDTH;
    localparam int ACC_W  = `MAC_ACC_WIDTH;
    localparam int CONF_W = `MAC_CONF_WIDTH;
    localparam int CFG_W  = ACC_W + CONF_W;
    // drain counter must hold MAC_LATENCY+1
    localparam int DRN_W  = $clog2(MAC_LATENCY + 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic [4*MIN_W-1:0] opa_q, opa_d;
    logic [MIN_W-1:0]   b2_q, b2_d;
    logic               en_q, en_d;
    logic [INT_W-1:0]   res_q, res_d;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0]        stall_q, stall_d;
`endif

    logic beat_accept;

    // state register and all datapath holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            drain_q  <= '0;
            cfg_q    <= '0;
            opa_q    <= '0;
            b2_q     <= '0;
            en_q     <= 1'b0;
            res_q    <= '0;
`ifdef MAC_SEQ_STALL_CNT_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            drain_q  <= drain_d;
            cfg_q    <= cfg_d;
            opa_q    <= opa_d;
            b2_q     <= b2_d;
            en_q     <= en_d;
            res_q    <= res_d;
`ifdef MAC_SEQ_STALL_CNT_EN
            stall_q  <= stall_d;
`endif
        end
    end

    // a beat is only taken in STREAM while beats remain
    assign beat_accept = (state_q == STREAM) && (remain_q != '0) && bus.op_valid;

    // next-state and next-value logic for the job sequence
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        drain_d  = drain_q;
        cfg_d    = cfg_q;
        opa_d    = opa_q;
        b2_d     = b2_q;
        en_d     = 1'b0;
        res_d    = res_q;
`ifdef MAC_SEQ_STALL_CNT_EN
        stall_d  = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.job_valid) begin
                    // cfg stays frozen from here until the next job is latched
                    cfg_d    = {bus.job_init, bus.job_acc, {(CONF_W-3){1'b0}}, bus.job_mode};
                    remain_d = bus.job_len;
`ifdef MAC_SEQ_STALL_CNT_EN
                    stall_d  = '0;
`endif
                    if (bus.job_len == '0) begin
                        // empty job: the result is just the init value, MAC untouched
                        res_d   = INT_W'(bus.job_init);
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // one quiet cycle lets the accumulator pick up init before beat 1
                state_d = STREAM;
            end
            STREAM: begin
                if (beat_accept) begin
                    opa_d    = bus.op_a;
                    b2_d     = bus.op_b;
                    en_d     = 1'b1;
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        drain_d = DRN_W'(MAC_LATENCY + 1);
                        state_d = DRAIN;
                    end
                end
`ifdef MAC_SEQ_STALL_CNT_EN
                else if ((remain_q != '0) && (stall_q != 16'hFFFF)) begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
            DRAIN: begin
                // operands keep their last values so a multiply-only pipeline holds its product
                if (drain_q == '0) begin
                    res_d   = bus.mac_c;
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.job_ready = (state_q == IDLE);
    assign bus.op_ready  = (state_q == STREAM) && (remain_q != '0);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = res_q;
    assign bus.mac_en    = en_q;
    assign bus.mac_cfg   = cfg_q;
    assign bus.mac_a0    = opa_q[0*MIN_W +: MIN_W];
    assign bus.mac_a1    = opa_q[1*MIN_W +: MIN_W];
    assign bus.mac_a2    = opa_q[2*MIN_W +: MIN_W];
    assign bus.mac_a3    = opa_q[3*MIN_W +: MIN_W];
    assign bus.mac_b2    = b2_q;
    assign busy          = (state_q != IDLE);
`ifdef MAC_SEQ_STALL_CNT_EN
    assign stall_cnt     = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - randomized self-checking bench for mac_seq_ctrl with a behavioural MAC
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_INT_WIDTH
`define MAC_INT_WIDTH 32
`endif
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 4
`endif

module tb_mac_seq_ctrl;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    mac_seq_ctrl_if #(.LEN_W(8)) bus();

    mac_seq_ctrl #(.LEN_W(8), .MAC_LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy)
`ifdef MAC_SEQ_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // MAC product for one beat: SINGLE A2*B2, DUAL adds A3*B2 one lane up, QUAD sums all lanes
    function automatic logic [31:0] prodf(input logic [1:0] mode, input logic [31:0] a, input logic [7:0] b);
        logic [31:0] p;
        p = 32'd0;
        case (mode)
            2'd0: p = 32'(a[23:16]) * 32'(b);
            2'd1: p = 32'(a[23:16]) * 32'(b) + ((32'(a[31:24]) * 32'(b)) << 8);
            default: for (int i = 0; i < 4; i++) p = p + ((32'(a[8*i +: 8]) * 32'(b)) << (8*i));
        endcase
        return p;
    endfunction

    // behavioural MAC block: registered product and an accumulator loaded the cycle after job accept
    logic [31:0] mac_acc, mac_prod;
    logic        mac_ld;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_acc  <= 32'd0;
            mac_prod <= 32'd0;
            mac_ld   <= 1'b0;
        end else begin
            mac_prod <= prodf(bus.mac_cfg[1:0], {bus.mac_a3, bus.mac_a2, bus.mac_a1, bus.mac_a0}, bus.mac_b2);
            mac_ld   <= bus.job_valid && bus.job_ready;
            if (mac_ld)
                mac_acc <= bus.mac_cfg[35:4];
            else if (bus.mac_en)
                mac_acc <= mac_acc + prodf(bus.mac_cfg[1:0], {bus.mac_a3, bus.mac_a2, bus.mac_a1, bus.mac_a0}, bus.mac_b2);
        end
    end
    assign bus.mac_c = bus.mac_cfg[3] ? mac_acc : mac_prod;

    // reference model: job-level bookkeeping, checked against the DUT every negedge
    logic        m_active, m_done, m_en, m_accf;
    logic [1:0]  m_mode;
    int          m_load_wait, m_left, m_drain;
    logic [31:0] m_res, m_rd, m_a;
    logic [7:0]  m_b;
    logic [35:0] m_cfg;
    logic        e_jr, e_opr;
    logic [31:0] res_log[$];
`ifdef MAC_SEQ_STALL_CNT_EN
    int          m_stall;
`endif

    always @(negedge clk) begin
        if (rst) begin
            m_active = 0; m_done = 0; m_en = 0; m_accf = 0; m_mode = 0;
            m_load_wait = 0; m_left = 0; m_drain = 0;
            m_res = 0; m_rd = 0; m_a = 0; m_b = 0; m_cfg = 0;
`ifdef MAC_SEQ_STALL_CNT_EN
            m_stall = 0;
`endif
        end else begin
            if (m_load_wait > 0) m_load_wait--;
            if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) begin
                    m_done = 1;
                    m_rd   = m_res;
                end
            end
        end
        e_jr  = !m_active;
        e_opr = m_active && (m_load_wait == 0) && (m_left > 0);
        chk("job_ready", 64'(bus.job_ready), 64'(e_jr));
        chk("busy", 64'(busy), 64'(m_active));
        chk("op_ready", 64'(bus.op_ready), 64'(e_opr));
        chk("res_valid", 64'(bus.res_valid), 64'(m_done));
        chk("res_data", 64'(bus.res_data), 64'(m_rd));
        chk("mac_en", 64'(bus.mac_en), 64'(m_en));
        chk("mac_cfg", 64'(bus.mac_cfg), 64'(m_cfg));
        chk("mac_a", 64'({bus.mac_a3, bus.mac_a2, bus.mac_a1, bus.mac_a0}), 64'(m_a));
        chk("mac_b2", 64'(bus.mac_b2), 64'(m_b));
`ifdef MAC_SEQ_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        if (!rst) begin
            m_en = e_opr && bus.op_valid;
`ifdef MAC_SEQ_STALL_CNT_EN
            if (e_opr && !bus.op_valid && m_stall < 65535) m_stall++;
`endif
            if (m_en) begin
                m_a = bus.op_a;
                m_b = bus.op_b;
                m_res = m_accf ? m_res + prodf(m_mode, bus.op_a, bus.op_b) : prodf(m_mode, bus.op_a, bus.op_b);
                m_left--;
                if (m_left == 0) m_drain = LAT + 3;
            end
            if (m_done && bus.res_ready) begin
                m_done = 0;
                m_active = 0;
                res_log.push_back(bus.res_data);
            end
            if (e_jr && bus.job_valid) begin
                m_active = 1;
                m_mode = bus.job_mode;
                m_accf = bus.job_acc;
                m_cfg = {bus.job_init, bus.job_acc, 1'b0, bus.job_mode};
                m_left = int'(bus.job_len);
                m_res = bus.job_acc ? bus.job_init : 32'd0;
`ifdef MAC_SEQ_STALL_CNT_EN
                m_stall = 0;
`endif
                if (m_left == 0) begin
                    m_res = bus.job_init;
                    m_drain = 1;
                end else begin
                    m_load_wait = 2;
                end
            end
        end
    end

    // directed beats and stall lengths; random when empty
    logic [31:0] qa[$];
    logic [7:0]  qb[$];
    int          qs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.job_valid = 0; bus.op_valid = 0; bus.res_ready = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // drive one job; abort_after>=0 pulses reset after that many beats
    task automatic run_job(input logic [1:0] mode, input logic acc, input logic [31:0] init, input int len,
                           input int stall_max, input int hold, input int abort_after, input logic glitch,
                           output logic [31:0] res, output int lat);
        bit ok;
        int st;
        int nlog;
        res = 32'd0;
        lat = 0;
        nlog = res_log.size();
        bus.job_valid = 1; bus.job_mode = mode; bus.job_acc = acc; bus.job_init = init; bus.job_len = 8'(len);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (bus.job_ready) begin ok = 1; tick(); break; end
            tick();
        end
        chk("job_accept_timeout", 64'(ok), 64'd1);
        bus.job_valid = 0;
        if (glitch) begin
            bus.job_valid = 1; bus.job_init = $urandom; bus.job_len = 8'($urandom_range(0, 3));
        end
        for (int i = 0; i < len; i++) begin
            if (i == abort_after) begin
                pulse_reset();
                return;
            end
            st = (qs.size() > 0) ? qs.pop_front() : int'($urandom_range(0, stall_max));
            bus.op_valid = 0;
            repeat (st) begin bus.res_ready = 1'($urandom); tick(); end
            bus.op_valid = 1;
            bus.op_a = (qa.size() > 0) ? qa.pop_front() : $urandom;
            bus.op_b = (qb.size() > 0) ? qb.pop_front() : 8'($urandom);
            ok = 0;
            for (int k = 0; k < 20; k++) begin
                if (bus.op_ready) begin ok = 1; tick(); break; end
                tick();
            end
            chk("beat_accept_timeout", 64'(ok), 64'd1);
        end
        bus.op_valid = 0;
        bus.res_ready = 0;
        while (!bus.res_valid && lat < 400) begin tick(); lat++; end
        chk("res_valid_timeout", 64'(bus.res_valid), 64'd1);
        bus.job_valid = 0;
        repeat (hold) tick();
        bus.res_ready = 1;
        tick();
        bus.res_ready = 0;
        chk("one_result_per_job", 64'(res_log.size()), 64'(nlog + 1));
        if (res_log.size() > 0) res = res_log[$];
    endtask

    logic [31:0] r;
    int          lat;
    int          nl;

    initial begin
        bus.job_valid = 0; bus.job_mode = 0; bus.job_acc = 0; bus.job_init = 0; bus.job_len = 0;
        bus.op_valid = 0; bus.op_a = 0; bus.op_b = 0; bus.res_ready = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_job_ready", 64'(bus.job_ready), 64'd1);
        chk("reset_res_data", 64'(bus.res_data), 64'd0);

        // 1: SINGLE accumulate, init 5, beats (2,3),(4,5),(1,1)
        qa = '{32'hAB02CD11, 32'h12043456, 32'hFF01FFFF}; qb = '{8'd3, 8'd5, 8'd1}; qs = '{0, 0, 0};
        run_job(2'd0, 1'b1, 32'd5, 3, 0, 0, -1, 1'b0, r, lat);
        chk("t1_sum", 64'(r), 64'd32);

        // 2: DUAL multiply-only, last beat A2=3 A3=1 B2=2
        qa = '{32'h07090000, 32'h01030000}; qb = '{8'd9, 8'd2}; qs = '{0, 0};
        run_job(2'd1, 1'b0, 32'd77, 2, 0, 0, -1, 1'b0, r, lat);
        chk("t2_product", 64'(r), 64'd518);
        chk("t2_latency", 64'(lat), 64'(LAT + 2));

        // 3: stall 3 cycles between beats 2 and 3
        qa = '{32'h00010000, 32'h00030000, 32'h00050000, 32'h00070000};
        qb = '{8'd2, 8'd4, 8'd6, 8'd8}; qs = '{0, 0, 3, 0};
        run_job(2'd0, 1'b1, 32'd0, 4, 0, 0, -1, 1'b0, r, lat);
        chk("t3_sum", 64'(r), 64'd100);
`ifdef MAC_SEQ_STALL_CNT_EN
        chk("t3_stall_cnt", 64'(stall_cnt), 64'd3);
`endif

        // 4: empty job with job_valid raised while busy
        run_job(2'd2, 1'b1, 32'd9, 0, 0, 0, -1, 1'b1, r, lat);
        chk("t4_init_passthru", 64'(r), 64'd9);
        nl = res_log.size();
        repeat (5) tick();
        chk("t4_no_second_result", 64'(res_log.size()), 64'(nl));

        // 5: consumer holds res_ready low for 10 cycles
        run_job(2'd0, 1'b1, 32'd1, 1, 0, 10, -1, 1'b0, r, lat);

        // 6: reset after 2 of 5 beats, then a one-beat job
        nl = res_log.size();
        run_job(2'd0, 1'b1, 32'd4, 5, 1, 0, 2, 1'b0, r, lat);
        chk("t6_busy_after_rst", 64'(busy), 64'd0);
        chk("t6_no_result", 64'(res_log.size()), 64'(nl));
        qa = '{32'h00030000}; qb = '{8'd3}; qs = '{0};
        run_job(2'd0, 1'b1, 32'd10, 1, 0, 0, -1, 1'b0, r, lat);
        chk("t6_new_job", 64'(r), 64'd19);

        // maximum-length job
        run_job(2'd2, 1'b1, $urandom, 255, 0, 1, -1, 1'b0, r, lat);

        // random jobs
        for (int j = 0; j < 60; j++) begin
            run_job(2'($urandom_range(0, 2)), 1'($urandom), $urandom,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1, 1'($urandom), r, lat);
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
